time_ctrl: RTL

//   Run controller for the game/stopwatch time base. Converts single-cycle start/pause/stop

---
 rtl/time_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/time_ctrl.sv
// ============================================================================
// Module   : time_ctrl
// Brief    : Run controller for the game/stopwatch time base (start/pause/stop
//            sequencing, prescaled elapsed-time count, limit timeout).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_ctrl #(
    parameter int TICK_DIV = 10,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset_start,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] time_counter,
    output logic             tick,
    output logic             running,
    output logic             paused,
    output logic             done,
    output logic             timeout
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic             tick_d, timeout_d;
    logic             begin_run, advance;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = time_counter + 1'b1;

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        cnt_d     = time_counter;
        lim_d     = lim_q;
        tick_d    = 1'b0;
        timeout_d = 1'b0;
        begin_run = 1'b0;
        advance   = 1'b0;

        // stop > pause > start; stop and pause have no effect in IDLE
        case (state_q)
            S_IDLE: begin
                if (start) begin_run = 1'b1;
            end
            S_RUN: begin
                if (stop)       state_d = S_IDLE;
                else if (pause) state_d = S_PAUSE;
                else            advance = 1'b1;
            end
            S_PAUSE: begin
                if (stop)                state_d = S_IDLE;
                else if (pause || start) advance = 1'b1;
            end
            S_DONE: begin
                if (stop)       state_d   = S_IDLE;
                else if (start) begin_run = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (begin_run) begin
            cnt_d = '0;
            pre_d = '0;
            lim_d = limit;
            if (limit == '0) begin
                state_d   = S_DONE;
                timeout_d = 1'b1;
            end else begin
                state_d = S_RUN;
            end
        end

        // The resume edge out of PAUSE counts like any RUN cycle, so a tick
        // that was suppressed by pause is delivered on resume.
        if (advance) begin
            state_d = S_RUN;
            if (pre_q == c_pre_last) begin
                pre_d  = '0;
                cnt_d  = cnt_inc;
                tick_d = 1'b1;
                if (cnt_inc == lim_q) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset_start) begin
        if (reset_start) begin
            state_q      <= S_IDLE;
            pre_q        <= '0;
            lim_q        <= '0;
            time_counter <= '0;
            tick         <= 1'b0;
            timeout      <= 1'b0;
            running      <= 1'b0;
            paused       <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            lim_q        <= lim_d;
            time_counter <= cnt_d;
            tick         <= tick_d;
            timeout      <= timeout_d;
            running      <= (state_d == S_RUN);
            paused       <= (state_d == S_PAUSE);
            done         <= (state_d == S_DONE);
        end
    end

endmodule

`default_nettype wire
